// File: rtl/up_drp_bridge.sv
// Processor-side bridge to a Xilinx-style DRP port: one outstanding access,
// bounded wait for drp_rdy, plus a synchronized MMCM/PLL lock status.
module up_drp_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DRP_ADDR_WIDTH = 7
) (
  input  logic                      up_clk,
  input  logic                      up_rstn,
  input  logic                      up_drp_sel,
  input  logic                      up_drp_wr,
  input  logic [11:0]               up_drp_addr,
  input  logic [31:0]               up_drp_wdata,
  output logic [31:0]               up_drp_rdata,
  output logic                      up_drp_ready,
  output logic                      up_drp_locked,
  output logic                      up_drp_timeout,
  output logic                      drp_en,
  output logic                      drp_we,
  output logic [DRP_ADDR_WIDTH-1:0] drp_addr,
  output logic [15:0]               drp_di,
  input  logic [15:0]               drp_do,
  input  logic                      drp_rdy,
  input  logic                      mmcm_locked
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] TERM_COUNT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] wait_count;
  logic [2:0]  lock_sync;

  // Only the low address bits and the low data half reach the primitive.
  logic unused_bits;
  assign unused_bits = ^{up_drp_wdata[31:16], up_drp_addr};

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state          <= IDLE;
      wait_count     <= 16'd0;
      drp_en         <= 1'b0;
      drp_we         <= 1'b0;
      drp_addr       <= '0;
      drp_di         <= 16'd0;
      up_drp_rdata   <= 32'd0;
      up_drp_ready   <= 1'b0;
      up_drp_timeout <= 1'b0;
    end else begin
      drp_en         <= 1'b0;
      drp_we         <= 1'b0;
      up_drp_ready   <= 1'b0;
      up_drp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (up_drp_sel) begin
            drp_addr   <= up_drp_addr[DRP_ADDR_WIDTH-1:0];
            drp_di     <= up_drp_wdata[15:0];
            drp_we     <= up_drp_wr;
            drp_en     <= 1'b1;
            wait_count <= 16'd0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (drp_rdy) begin
            up_drp_rdata <= {16'h0000, drp_do};
            up_drp_ready <= 1'b1;
            state        <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // A ready on the terminal count cycle still counts as a normal completion.
          if (drp_rdy) begin
            up_drp_rdata <= {16'h0000, drp_do};
            up_drp_ready <= 1'b1;
            state        <= DONE;
          end else if (wait_count == TERM_COUNT) begin
            up_drp_rdata   <= 32'hFFFF_FFFF;
            up_drp_ready   <= 1'b1;
            up_drp_timeout <= 1'b1;
            state          <= DONE;
          end else begin
            wait_count <= wait_count + 16'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      lock_sync <= 3'b000;
    end else begin
      lock_sync <= {lock_sync[1:0], mmcm_locked};
    end
  end

  assign up_drp_locked = lock_sync[2];

endmodule

// File: tb/tb_up_drp_bridge.sv
// Self-checking bench for up_drp_bridge: table-driven transactions with a
// completion scoreboard, plus busy-drop, idle-ready, reset-abort and lock sequences.
module tb_up_drp_bridge;

  localparam int TOUT = 8;

  logic        up_clk;
  logic        up_rstn;
  logic        up_drp_sel;
  logic        up_drp_wr;
  logic [11:0] up_drp_addr;
  logic [31:0] up_drp_wdata;
  logic [31:0] up_drp_rdata;
  logic        up_drp_ready;
  logic        up_drp_locked;
  logic        up_drp_timeout;
  logic        drp_en;
  logic        drp_we;
  logic [6:0]  drp_addr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_rdy;
  logic        mmcm_locked;

  up_drp_bridge #(
    .TIMEOUT_CYCLES(TOUT),
    .DRP_ADDR_WIDTH(7)
  ) dut (
    .up_clk        (up_clk),
    .up_rstn       (up_rstn),
    .up_drp_sel    (up_drp_sel),
    .up_drp_wr     (up_drp_wr),
    .up_drp_addr   (up_drp_addr),
    .up_drp_wdata  (up_drp_wdata),
    .up_drp_rdata  (up_drp_rdata),
    .up_drp_ready  (up_drp_ready),
    .up_drp_locked (up_drp_locked),
    .up_drp_timeout(up_drp_timeout),
    .drp_en        (drp_en),
    .drp_we        (drp_we),
    .drp_addr      (drp_addr),
    .drp_di        (drp_di),
    .drp_do        (drp_do),
    .drp_rdy       (drp_rdy),
    .mmcm_locked   (mmcm_locked)
  );

  initial up_clk = 1'b0;
  always #5 up_clk = ~up_clk;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          gap;
    logic [15:0] dout;
    logic [6:0]  exp_addr;
    logic [15:0] exp_di;
    logic [31:0] exp_rdata;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        timeout;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   en_pulses = 0;
  int   ready_pulses = 0;

  // Pre-update values are read at the rising edge, so each count reflects the cycle just ended.
  always @(posedge up_clk) begin
    if (drp_en) en_pulses++;
    if (up_drp_ready) ready_pulses++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic noteFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: actual=missing expected=present", name);
  endtask

  // Entered on the negedge inside the ISSUE cycle; gap<0 never raises drp_rdy.
  task automatic waitCompletion(input string tag, input int gap, input logic [15:0] dout,
                                input int exp_lat);
    bit   done = 1'b0;
    exp_t e;
    e.rdata   = 32'd0;
    e.timeout = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      drp_rdy = (cyc == gap);
      drp_do  = dout;
      @(negedge up_clk);
      drp_rdy = 1'b0;
      if (cyc == 0) checkOutput({tag, "_en_low"}, {31'd0, drp_en}, 32'd0);
      if (up_drp_ready) begin
        done = 1'b1;
        checkOutput({tag, "_latency"}, cyc, exp_lat);
        if (sb.size() == 0) begin
          noteFail({tag, "_scoreboard"});
        end else begin
          e = sb.pop_front();
          checkOutput({tag, "_rdata"}, up_drp_rdata, e.rdata);
          checkOutput({tag, "_timeout"}, {31'd0, up_drp_timeout}, {31'd0, e.timeout});
        end
      end
    end
    if (!done) begin
      noteFail({tag, "_ready_bound"});
    end else begin
      @(negedge up_clk);
      checkOutput({tag, "_ready_pulse"}, {31'd0, up_drp_ready}, 32'd0);
      checkOutput({tag, "_timeout_pulse"}, {31'd0, up_drp_timeout}, 32'd0);
      checkOutput({tag, "_rdata_hold"}, up_drp_rdata, e.rdata);
    end
  endtask

  task automatic applyStimulus(input string tag, input vec_t v);
    exp_t e;
    up_drp_sel   = 1'b1;
    up_drp_wr    = v.wr;
    up_drp_addr  = v.addr;
    up_drp_wdata = v.wdata;
    e.rdata      = v.exp_rdata;
    e.timeout    = v.exp_to;
    sb.push_back(e);
    @(negedge up_clk);
    up_drp_sel = 1'b0;
    checkOutput({tag, "_en"}, {31'd0, drp_en}, 32'd1);
    checkOutput({tag, "_we"}, {31'd0, drp_we}, {31'd0, v.wr});
    checkOutput({tag, "_addr"}, {25'd0, drp_addr}, {25'd0, v.exp_addr});
    checkOutput({tag, "_di"}, {16'd0, drp_di}, {16'd0, v.exp_di});
    waitCompletion(tag, v.gap, v.dout, v.exp_lat);
  endtask

  initial begin
    int   en0;
    int   rdy0;
    exp_t e;
    string tag;

    vecs[0] = '{1'b0, 12'h028, 32'h0000_0000, 3, 16'h1234, 7'h28, 16'h0000, 32'h0000_1234, 1'b0, 3};
    vecs[1] = '{1'b1, 12'hF4E, 32'hABCD_5A5A, 1, 16'h0BEE, 7'h4E, 16'h5A5A, 32'h0000_0BEE, 1'b0, 1};
    vecs[2] = '{1'b0, 12'h07F, 32'h1111_2222, 0, 16'hFFFF, 7'h7F, 16'h2222, 32'h0000_FFFF, 1'b0, 0};
    vecs[3] = '{1'b0, 12'h000, 32'h0000_0000, -1, 16'h9999, 7'h00, 16'h0000, 32'hFFFF_FFFF, 1'b1, TOUT};
    vecs[4] = '{1'b1, 12'h155, 32'h0000_C3C3, TOUT, 16'h0042, 7'h55, 16'hC3C3, 32'h0000_0042, 1'b0, TOUT};
    vecs[5] = '{1'b0, 12'h0AA, 32'h0000_0000, TOUT - 1, 16'h7777, 7'h2A, 16'h0000, 32'h0000_7777, 1'b0, TOUT - 1};

    up_rstn      = 1'b0;
    up_drp_sel   = 1'b0;
    up_drp_wr    = 1'b0;
    up_drp_addr  = 12'd0;
    up_drp_wdata = 32'd0;
    drp_do       = 16'd0;
    drp_rdy      = 1'b0;
    mmcm_locked  = 1'b0;

    repeat (3) @(negedge up_clk);
    checkOutput("reset_en", {31'd0, drp_en}, 32'd0);
    checkOutput("reset_addr", {25'd0, drp_addr}, 32'd0);
    checkOutput("reset_rdata", up_drp_rdata, 32'd0);
    checkOutput("reset_ready", {31'd0, up_drp_ready}, 32'd0);
    checkOutput("reset_locked", {31'd0, up_drp_locked}, 32'd0);
    up_rstn = 1'b1;
    @(negedge up_clk);

    for (int i = 0; i < 6; i++) begin
      tag = $sformatf("vec%0d", i);
      applyStimulus(tag, vecs[i]);
      @(negedge up_clk);
    end

    // drp_rdy while idle must not disturb the held completion data.
    rdy0    = ready_pulses;
    drp_rdy = 1'b1;
    drp_do  = 16'hBEEF;
    @(negedge up_clk);
    drp_rdy = 1'b0;
    @(negedge up_clk);
    checkOutput("idle_rdy_rdata", up_drp_rdata, 32'h0000_7777);
    checkOutput("idle_rdy_pulses", ready_pulses - rdy0, 0);

    // Second request two cycles after the first is dropped.
    en0          = en_pulses;
    rdy0         = ready_pulses;
    up_drp_sel   = 1'b1;
    up_drp_wr    = 1'b0;
    up_drp_addr  = 12'h011;
    e.rdata      = 32'h0000_0321;
    e.timeout    = 1'b0;
    sb.push_back(e);
    @(negedge up_clk);
    up_drp_sel = 1'b0;
    checkOutput("busy_en", {31'd0, drp_en}, 32'd1);
    @(negedge up_clk);
    up_drp_sel  = 1'b1;
    up_drp_addr = 12'h066;
    @(negedge up_clk);
    up_drp_sel = 1'b0;
    checkOutput("busy_addr_held", {25'd0, drp_addr}, 32'h11);
    waitCompletion("busy", 0, 16'h0321, 0);
    repeat (12) @(negedge up_clk);
    checkOutput("busy_en_count", en_pulses - en0, 1);
    checkOutput("busy_ready_count", ready_pulses - rdy0, 1);

    // Reset while waiting aborts silently; a late drp_rdy is ignored.
    rdy0         = ready_pulses;
    up_drp_sel   = 1'b1;
    up_drp_wr    = 1'b1;
    up_drp_addr  = 12'h033;
    up_drp_wdata = 32'h0000_ABCD;
    @(negedge up_clk);
    up_drp_sel = 1'b0;
    @(negedge up_clk);
    @(negedge up_clk);
    up_rstn = 1'b0;
    @(negedge up_clk);
    up_rstn = 1'b1;
    drp_rdy = 1'b1;
    drp_do  = 16'hDEAD;
    @(negedge up_clk);
    drp_rdy = 1'b0;
    checkOutput("rst_ready", {31'd0, up_drp_ready}, 32'd0);
    checkOutput("rst_rdata", up_drp_rdata, 32'd0);
    checkOutput("rst_addr", {25'd0, drp_addr}, 32'd0);
    checkOutput("rst_di", {16'd0, drp_di}, 32'd0);
    checkOutput("rst_en_we", {30'd0, drp_en, drp_we}, 32'd0);
    repeat (4) @(negedge up_clk);
    checkOutput("rst_no_pulse", ready_pulses - rdy0, 0);
    checkOutput("rst_timeout", {31'd0, up_drp_timeout}, 32'd0);

    // Lock synchronizer: visible after the third rising edge in each direction.
    mmcm_locked = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge up_clk);
      checkOutput($sformatf("lock_rise_%0d", k), {31'd0, up_drp_locked}, {31'd0, k == 3});
    end
    mmcm_locked = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge up_clk);
      checkOutput($sformatf("lock_fall_%0d", k), {31'd0, up_drp_locked}, {31'd0, k != 3});
    end

    checkOutput("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
